// File: rtl/instr_decode.sv
// PDP-8 fetch/decode front end: fetches, resolves one level of indirection and
// presents one opcode at a time to instr_exec. Optional macro: AUTO_INDEX_EN.
package instr_decode_pkg;
  typedef struct packed {
    logic        AND;
    logic        TAD;
    logic        ISZ;
    logic        DCA;
    logic        JMS;
    logic        JMP;
    logic [11:0] mem_inst_addr;
  } pdp_mem_opcode_s;

  typedef struct packed {
    logic NOP, IAC, RAL, RTL, RAR, RTR, CML, CMA, CIA, CLL, CLA1, CLA_CLL;
    logic HLT, OSR, SKP, SNL, SZL, SZA, SNA, SMA, SPA, CLA2;
  } pdp_op7_opcode_s;

  localparam logic [11:0] OP7_IAC = 12'o7001, OP7_RAL = 12'o7004, OP7_RTL = 12'o7006;
  localparam logic [11:0] OP7_RAR = 12'o7010, OP7_RTR = 12'o7012, OP7_CML = 12'o7020;
  localparam logic [11:0] OP7_CMA = 12'o7040, OP7_CIA = 12'o7041, OP7_CLL = 12'o7100;
  localparam logic [11:0] OP7_CLA1 = 12'o7200, OP7_CLA_CLL = 12'o7300, OP7_HLT = 12'o7402;
  localparam logic [11:0] OP7_OSR = 12'o7404, OP7_SKP = 12'o7410, OP7_SNL = 12'o7420;
  localparam logic [11:0] OP7_SZL = 12'o7430, OP7_SZA = 12'o7440, OP7_SNA = 12'o7450;
  localparam logic [11:0] OP7_SMA = 12'o7500, OP7_SPA = 12'o7510, OP7_CLA2 = 12'o7600;
endpackage

module instr_decode
  import instr_decode_pkg::*;
#(
  parameter int unsigned RD_LATENCY = 1,
  parameter logic [11:0] START_ADDR = 12'o0200
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [11:0]     base_addr,
  input  logic [11:0]     PC_value,
  input  logic            stall,
  output logic            ifu_rd_req,
  output logic [11:0]     ifu_rd_addr,
  input  logic [11:0]     ifu_rd_data,
`ifdef AUTO_INDEX_EN
  output logic            ifu_wr_req,
  output logic [11:0]     ifu_wr_addr,
  output logic [11:0]     ifu_wr_data,
`endif
  output pdp_mem_opcode_s pdp_mem_opcode,
  output pdp_op7_opcode_s pdp_op7_opcode
);

  typedef enum logic [3:0] {
    IDLE, FETCH, WAIT_F, DECODE, IND_RD, WAIT_I,
`ifdef AUTO_INDEX_EN
    AI_WR,
`endif
    ISSUE, DONE
  } state_e;

  localparam logic [2:0] LAT_LAST = 3'(RD_LATENCY - 1);

  state_e          r_state, w_next;
  logic [11:0]     r_pc, r_ir, r_ea;
  logic [2:0]      r_cnt;
  pdp_mem_opcode_s r_mem;
  pdp_op7_opcode_s r_op7;
  logic            w_rd_done, w_is_mem;
  logic [2:0]      w_opc;
  logic [11:0]     w_ea;
`ifdef AUTO_INDEX_EN
  logic [11:0]     r_ptr;
  logic            w_auto;
  assign w_auto = (r_ea[11:3] == 9'o001);
`endif

  function automatic pdp_mem_opcode_s mem_issue(input logic [2:0] opc, input logic [11:0] addr);
    pdp_mem_opcode_s m;
    m = '0;
    m.mem_inst_addr = addr;
    case (opc)
      3'd0:    m.AND = 1'b1;
      3'd1:    m.TAD = 1'b1;
      3'd2:    m.ISZ = 1'b1;
      3'd3:    m.DCA = 1'b1;
      3'd4:    m.JMS = 1'b1;
      3'd5:    m.JMP = 1'b1;
      default: ;
    endcase
    return m;
  endfunction

  // IOT, group-3 and any word not matching an exact encoding decode as NOP.
  function automatic pdp_op7_opcode_s decode_op7(input logic [11:0] ir);
    pdp_op7_opcode_s o;
    o = '0;
    case (ir)
      OP7_IAC:     o.IAC = 1'b1;
      OP7_RAL:     o.RAL = 1'b1;
      OP7_RTL:     o.RTL = 1'b1;
      OP7_RAR:     o.RAR = 1'b1;
      OP7_RTR:     o.RTR = 1'b1;
      OP7_CML:     o.CML = 1'b1;
      OP7_CMA:     o.CMA = 1'b1;
      OP7_CIA:     o.CIA = 1'b1;
      OP7_CLL:     o.CLL = 1'b1;
      OP7_CLA1:    o.CLA1 = 1'b1;
      OP7_CLA_CLL: o.CLA_CLL = 1'b1;
      OP7_HLT:     o.HLT = 1'b1;
      OP7_OSR:     o.OSR = 1'b1;
      OP7_SKP:     o.SKP = 1'b1;
      OP7_SNL:     o.SNL = 1'b1;
      OP7_SZL:     o.SZL = 1'b1;
      OP7_SZA:     o.SZA = 1'b1;
      OP7_SNA:     o.SNA = 1'b1;
      OP7_SMA:     o.SMA = 1'b1;
      OP7_SPA:     o.SPA = 1'b1;
      OP7_CLA2:    o.CLA2 = 1'b1;
      default:     o.NOP = 1'b1;
    endcase
    return o;
  endfunction

  assign w_rd_done = (r_cnt == LAT_LAST);
  assign w_opc     = r_ir[11:9];
  assign w_is_mem  = !(r_ir[11] && r_ir[10]);
  assign w_ea      = r_ir[7] ? {r_pc[11:7], r_ir[6:0]} : {5'b0, r_ir[6:0]};

  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = FETCH;
      FETCH:   w_next = WAIT_F;
      WAIT_F:  if (w_rd_done) w_next = DECODE;
      DECODE:  w_next = (w_is_mem && r_ir[8]) ? IND_RD : ISSUE;
      IND_RD:  w_next = WAIT_I;
`ifdef AUTO_INDEX_EN
      WAIT_I:  if (w_rd_done) w_next = w_auto ? AI_WR : ISSUE;
      AI_WR:   w_next = ISSUE;
`else
      WAIT_I:  if (w_rd_done) w_next = ISSUE;
`endif
      ISSUE:   if (stall) w_next = DONE;
      DONE:    if (!stall) w_next = FETCH;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    ifu_rd_req  = 1'b0;
    ifu_rd_addr = '0;
`ifdef AUTO_INDEX_EN
    ifu_wr_req  = 1'b0;
    ifu_wr_addr = '0;
    ifu_wr_data = '0;
`endif
    case (r_state)
      FETCH: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = r_pc;
      end
      IND_RD: begin
        ifu_rd_req  = 1'b1;
        ifu_rd_addr = r_ea;
      end
`ifdef AUTO_INDEX_EN
      AI_WR: begin
        ifu_wr_req  = 1'b1;
        ifu_wr_addr = r_ea;
        ifu_wr_data = r_ptr + 12'd1;
      end
`endif
      default: ;
    endcase
  end

  assign pdp_mem_opcode = r_mem;
  assign pdp_op7_opcode = r_op7;

  // Opcode fields load only on the transition into ISSUE, so nothing is visible mid-fetch.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc  <= (base_addr == '0) ? START_ADDR : base_addr;
      r_ir  <= '0;
      r_ea  <= '0;
      r_cnt <= '0;
      r_mem <= '0;
      r_op7 <= '0;
`ifdef AUTO_INDEX_EN
      r_ptr <= '0;
`endif
    end else begin
      case (r_state)
        FETCH, IND_RD: r_cnt <= '0;
        WAIT_F: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_rd_done) r_ir <= ifu_rd_data;
        end
        DECODE: begin
          r_ea <= w_ea;
          if (!w_is_mem)    r_op7 <= decode_op7(r_ir);
          else if (!r_ir[8]) r_mem <= mem_issue(w_opc, w_ea);
        end
        WAIT_I: begin
          r_cnt <= r_cnt + 3'd1;
          if (w_rd_done) begin
`ifdef AUTO_INDEX_EN
            r_ptr <= ifu_rd_data;
            if (!w_auto) r_mem <= mem_issue(w_opc, ifu_rd_data);
`else
            r_mem <= mem_issue(w_opc, ifu_rd_data);
`endif
          end
        end
`ifdef AUTO_INDEX_EN
        AI_WR: r_mem <= mem_issue(w_opc, r_ptr + 12'd1);
`endif
        DONE: begin
          if (!stall) begin
            r_mem <= '0;
            r_op7 <= '0;
            r_pc  <= PC_value;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_decode.sv
// Bench for instr_decode: table of instructions run through a latency-modelled memory,
// plus a mid-indirect reset sequence. Honours AUTO_INDEX_EN when defined.
module tb_instr_decode;
  import instr_decode_pkg::*;

  localparam int unsigned LAT = 3;
`ifdef AUTO_INDEX_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n, stall, rd_req;
  logic [11:0]     base_addr, PC_value, rd_addr, rd_data;
  pdp_mem_opcode_s mem_o;
  pdp_op7_opcode_s op7_o;
`ifdef AUTO_INDEX_EN
  logic            wr_req;
  logic [11:0]     wr_addr, wr_data;
`endif

  instr_decode #(.RD_LATENCY(LAT), .START_ADDR(12'o0200)) dut (
    .clk(clk), .reset_n(reset_n), .base_addr(base_addr), .PC_value(PC_value),
    .stall(stall), .ifu_rd_req(rd_req), .ifu_rd_addr(rd_addr), .ifu_rd_data(rd_data),
`ifdef AUTO_INDEX_EN
    .ifu_wr_req(wr_req), .ifu_wr_addr(wr_addr), .ifu_wr_data(wr_data),
`endif
    .pdp_mem_opcode(mem_o), .pdp_op7_opcode(op7_o)
  );

  // Memory: data valid exactly LAT cycles after the strobe, garbage otherwise.
  logic [11:0] mem [4096];
  logic        pv [LAT] = '{default: 1'b0};
  logic [11:0] pa [LAT] = '{default: 12'o0};
  always @(posedge clk) begin
    pv[0] <= rd_req;
    pa[0] <= rd_addr;
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
  end
  assign rd_data = pv[LAT-1] ? mem[pa[LAT-1]] : 12'o5555;

  typedef enum {S_NONE, S_NOP, S_IAC, S_CLA1, S_HLT, S_CIA} sel_e;
  typedef struct {
    logic [11:0] pc, word, ea, iw, nxt, maddr;
    bit ind, ai;
    int hold, mop;
    sel_e sel;
  } vec_t;
  typedef struct { pdp_mem_opcode_s m; pdp_op7_opcode_s o; int lat; } exp_t;
  typedef struct { int c; logic [11:0] a; } acc_t;
  typedef struct { logic [11:0] a, d; } wr_t;

  exp_t exp_q [$];
  acc_t rd_q [$];
  wr_t  wr_q [$];
  int   n_checks = 0, n_fail = 0, cyc = 0, b2b = 0;
  bit   prev_req = 1'b0;

  function automatic vec_t V(input logic [11:0] pc, word, input bit ind, input logic [11:0] ea, iw,
                             input bit ai, input logic [11:0] nxt, input int hold, mop,
                             input logic [11:0] maddr, input sel_e sel);
    vec_t v;
    v.pc = pc; v.word = word; v.ind = ind; v.ea = ea; v.iw = iw; v.ai = ai;
    v.nxt = nxt; v.hold = hold; v.mop = mop; v.maddr = maddr; v.sel = sel;
    return v;
  endfunction

  function automatic pdp_mem_opcode_s mk_mem(input int op, input logic [11:0] a);
    pdp_mem_opcode_s m;
    m = '0;
    if (op >= 0) begin
      m.mem_inst_addr = a;
      case (op)
        0: m.AND = 1'b1;
        1: m.TAD = 1'b1;
        2: m.ISZ = 1'b1;
        3: m.DCA = 1'b1;
        4: m.JMS = 1'b1;
        5: m.JMP = 1'b1;
        default: ;
      endcase
    end
    return m;
  endfunction

  function automatic pdp_op7_opcode_s mk_op7(input sel_e s);
    pdp_op7_opcode_s o;
    o = '0;
    case (s)
      S_NOP:   o.NOP = 1'b1;
      S_IAC:   o.IAC = 1'b1;
      S_CLA1:  o.CLA1 = 1'b1;
      S_HLT:   o.HLT = 1'b1;
      S_CIA:   o.CIA = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Every wait goes through here so memory-port activity is recorded in one place.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (rd_req) begin
      rd_q.push_back('{c: cyc, a: rd_addr});
      if (prev_req) b2b++;
    end
    prev_req = rd_req;
`ifdef AUTO_INDEX_EN
    if (wr_req) wr_q.push_back('{a: wr_addr, d: wr_data});
`endif
  endtask

  task automatic wait_issue(output bit ok);
    int k;
    k = 0;
    while (mem_o == '0 && op7_o == '0 && k < 80) begin
      tick();
      k++;
    end
    ok = (mem_o != '0 || op7_o != '0);
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    acc_t r;
    wr_t  w;
    bit   ok, stable, noreq;
    logic [11:0] ma;
    ma = (AI && v.ai) ? v.maddr + 12'd1 : v.maddr;
    e.m = mk_mem(v.mop, ma);
    e.o = mk_op7(v.sel);
    e.lat = v.ind ? int'(2*LAT + 3) + int'(AI && v.ai) : int'(LAT + 2);
    exp_q.push_back(e);
    wait_issue(ok);
    chk("issue_seen", 64'(ok), 64'(1));
    e = exp_q.pop_front();
    chk("mem_opcode", 64'(mem_o), 64'(e.m));
    chk("op7_opcode", 64'(op7_o), 64'(e.o));
    chk("n_reads", 64'(rd_q.size()), 64'(1 + int'(v.ind)));
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      chk("fetch_addr", 64'(r.a), 64'(v.pc));
      chk("latency", 64'(cyc - r.c), 64'(e.lat));
    end
    if (v.ind && rd_q.size() > 0) begin
      r = rd_q.pop_front();
      chk("ind_addr", 64'(r.a), 64'(v.ea));
    end
    rd_q.delete();
    chk("n_writes", 64'(wr_q.size()), 64'(AI && v.ai));
    if (wr_q.size() > 0) begin
      w = wr_q.pop_front();
      chk("wr_addr", 64'(w.a), 64'(v.ea));
      chk("wr_data", 64'(w.d), 64'(v.iw + 12'd1));
    end
    wr_q.delete();
    stall = 1'b1;
    stable = 1'b1;
    noreq = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      tick();
      if (mem_o !== e.m || op7_o !== e.o) stable = 1'b0;
      if (rd_req) noreq = 1'b0;
    end
    chk("hold_stable", 64'(stable), 64'(1));
    chk("hold_noreq", 64'(noreq), 64'(1));
    PC_value = v.nxt;
    stall = 1'b0;
    tick();
    chk("clr_mem", 64'(mem_o), 64'(0));
    chk("clr_op7", 64'(op7_o), 64'(0));
    chk("refetch_req", 64'(rd_req), 64'(1));
    chk("refetch_addr", 64'(rd_addr), 64'(v.nxt));
  endtask

  initial begin
    vec_t vt [12];
    bit   found, ok;
    int   k;
    acc_t r;
    vt[0]  = V(12'o0200, 12'o1205, 0, 12'o0,    12'o0,    0, 12'o0201, 3,  1, 12'o0205, S_NONE);
    vt[1]  = V(12'o0201, 12'o5410, 1, 12'o0010, 12'o3000, 1, 12'o0202, 3,  5, 12'o3000, S_NONE);
    vt[2]  = V(12'o0202, 12'o7001, 0, 12'o0,    12'o0,    0, 12'o0203, 3, -1, 12'o0,    S_IAC);
    vt[3]  = V(12'o0203, 12'o7200, 0, 12'o0,    12'o0,    0, 12'o0204, 3, -1, 12'o0,    S_CLA1);
    vt[4]  = V(12'o0204, 12'o7402, 0, 12'o0,    12'o0,    0, 12'o4000, 3, -1, 12'o0,    S_HLT);
    vt[5]  = V(12'o4000, 12'o6001, 0, 12'o0,    12'o0,    0, 12'o4001, 20, -1, 12'o0,   S_NOP);
    vt[6]  = V(12'o4001, 12'o7401, 0, 12'o0,    12'o0,    0, 12'o7777, 3, -1, 12'o0,    S_NOP);
    vt[7]  = V(12'o7777, 12'o0377, 0, 12'o0,    12'o0,    0, 12'o0300, 3,  0, 12'o7777, S_NONE);
    vt[8]  = V(12'o0300, 12'o4620, 1, 12'o0220, 12'o1234, 0, 12'o0301, 3,  4, 12'o1234, S_NONE);
    vt[9]  = V(12'o0301, 12'o2017, 0, 12'o0,    12'o0,    0, 12'o0302, 3,  2, 12'o0017, S_NONE);
    vt[10] = V(12'o0302, 12'o3417, 1, 12'o0017, 12'o7777, 1, 12'o0303, 3,  3, 12'o7777, S_NONE);
    vt[11] = V(12'o0303, 12'o7041, 0, 12'o0,    12'o0,    0, 12'o0304, 3, -1, 12'o0,    S_CIA);

    for (int a = 0; a < 4096; a++) mem[a] = 12'o0;
    foreach (vt[i]) begin
      mem[vt[i].pc] = vt[i].word;
      if (vt[i].ind) mem[vt[i].ea] = vt[i].iw;
    end
    mem[12'o0304] = 12'o5410;

    reset_n = 1'b0;
    base_addr = 12'o0200;
    PC_value = 12'o0;
    stall = 1'b0;
    repeat (3) tick();
    chk("rst_mem", 64'(mem_o), 64'(0));
    chk("rst_op7", 64'(op7_o), 64'(0));
    chk("rst_rdreq", 64'(rd_req), 64'(0));
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) run_vec(vt[i]);

    // Reset lands in WAIT_I; the returning pointer read must be ignored.
    found = 1'b0;
    k = 0;
    while (!found && k < 40) begin
      tick();
      k++;
      if (rd_req && rd_addr == 12'o0010) found = 1'b1;
    end
    chk("ind_rd_before_reset", 64'(found), 64'(1));
    tick();
    reset_n = 1'b0;
    base_addr = 12'o0;
    stall = 1'b1;
    tick();
    chk("midrst_rdreq", 64'(rd_req), 64'(0));
    chk("midrst_mem", 64'(mem_o), 64'(0));
    chk("midrst_op7", 64'(op7_o), 64'(0));
    tick();
    reset_n = 1'b1;
    rd_q.delete();
    wait_issue(ok);
    chk("restart_issue_seen", 64'(ok), 64'(1));
    chk("restart_mem", 64'(mem_o), 64'(mk_mem(1, 12'o0205)));
    chk("restart_op7", 64'(op7_o), 64'(0));
    chk("restart_n_reads", 64'(rd_q.size()), 64'(1));
    if (rd_q.size() > 0) begin
      r = rd_q.pop_front();
      chk("restart_fetch_addr", 64'(r.a), 64'(12'o0200));
      chk("restart_latency", 64'(cyc - r.c), 64'(LAT + 2));
    end
    repeat (4) tick();
    chk("restart_hold", 64'(mem_o), 64'(mk_mem(1, 12'o0205)));
    PC_value = 12'o0400;
    stall = 1'b0;
    tick();
    chk("restart_clr", 64'(mem_o), 64'(0));
    chk("restart_refetch", 64'({rd_req, rd_addr}), 64'({1'b1, 12'o0400}));
    chk("no_b2b_reads", 64'(b2b), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
